// File: rtl/bram_array_ctrl_if.sv
// Command/status and stream-tap bundle between the BRAM array run controller,
// the register block and the BRAM array.
interface bram_array_ctrl_if #(
    parameter int DEPTH_W  = 16,
    parameter int REPEAT_W = 8
);
    logic                cmd_start;
    logic [DEPTH_W-1:0]  cmd_depth;
    logic [REPEAT_W-1:0] cmd_repeat;
    logic                cmd_abort;
    logic                busy;
    logic                done;
    logic [1:0]          err_code;
    logic                BRAM_en;
    logic [1:0]          BRAM_Opts;
    logic [15:0]         BRAM_Depth;
    logic [1:0]          BRAM_Status;
    logic                wr_tvalid;
    logic                wr_tready;
    logic                wr_tlast;
    logic                rd_tvalid;
    logic                rd_tready;
    logic                rd_tlast;

    modport master (
        input  cmd_start, cmd_depth, cmd_repeat, cmd_abort, BRAM_Status,
        input  wr_tvalid, wr_tready, wr_tlast, rd_tvalid, rd_tready, rd_tlast,
        output busy, done, err_code, BRAM_en, BRAM_Opts, BRAM_Depth
    );

    modport slave (
        output cmd_start, cmd_depth, cmd_repeat, cmd_abort, BRAM_Status,
        output wr_tvalid, wr_tready, wr_tlast, rd_tvalid, rd_tready, rd_tlast,
        input  busy, done, err_code, BRAM_en, BRAM_Opts, BRAM_Depth
    );
endinterface

// File: rtl/bram_array_ctrl.sv
// Runs one reset -> fill -> N x playback sequence of the BRAM array per start command, checking beat count and tlast placement.
// Latency: all outputs registered; a status wait exits the cycle after the array reports it; done pulses after the last playback stop.
// Backpressure: passive stream taps, beats count on valid&ready only; BRAM_CTRL_TIMEOUT_EN adds a watchdog on status waits.
module bram_array_ctrl #(
    parameter int DEPTH_W     = 16,
    parameter int REPEAT_W    = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    bram_array_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_WR, S_WSTOP, S_RD, S_RSTOP, S_DONE, S_STOP
    } state_t;

    localparam logic [1:0] OPT_RST = 2'b00;
    localparam logic [1:0] OPT_WR  = 2'b01;
    localparam logic [1:0] OPT_RD  = 2'b10;
    localparam logic [1:0] OPT_STP = 2'b11;

    localparam logic [1:0] STS_RST  = 2'b00;
    localparam logic [1:0] STS_WAIT = 2'b01;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TLAST   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_ABORT   = 2'b11;

    localparam logic [DEPTH_W-1:0]  DEPTH_ONE = DEPTH_W'(1);
    localparam logic [REPEAT_W-1:0] PASS_ONE  = REPEAT_W'(1);

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    state_t              state;
    logic [DEPTH_W-1:0]  depth_m1;
    logic [DEPTH_W-1:0]  beat;
    logic [REPEAT_W-1:0] rep_q;
    logic [REPEAT_W-1:0] pass;
    logic                active;
    logic                run_beat;
    logic                run_last;
    logic                beat_is_last;
    logic                wd_expired;

    // DONE and STOP are already winding down, so abort only applies before them.
    assign active = (state != S_IDLE) && (state != S_DONE) && (state != S_STOP);

    assign run_beat = (state == S_WR) ? (bus.wr_tvalid & bus.wr_tready) :
                      (state == S_RD) ? (bus.rd_tvalid & bus.rd_tready) : 1'b0;
    assign run_last     = (state == S_WR) ? bus.wr_tlast : bus.rd_tlast;
    assign beat_is_last = (beat == depth_m1);

`ifdef BRAM_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic            waiting;
    logic [WD_W-1:0] wd_cnt;

    // Wait states are never adjacent, so clearing outside them restarts the count on every entry.
    assign waiting    = (state == S_RST) || (state == S_WSTOP) || (state == S_RSTOP);
    assign wd_expired = waiting && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (waiting && !wd_expired) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end else begin
            wd_cnt <= '0;
        end
    end
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            bus.BRAM_en    <= 1'b0;
            bus.BRAM_Opts  <= OPT_STP;
            bus.BRAM_Depth <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.err_code   <= ERR_NONE;
            depth_m1       <= '0;
            rep_q          <= '0;
            beat           <= '0;
            pass           <= '0;
        end else begin
            bus.done <= 1'b0;
            if (active && bus.cmd_abort) begin
                bus.err_code  <= ERR_ABORT;
                bus.BRAM_Opts <= OPT_STP;
                state         <= S_STOP;
            end else if (wd_expired) begin
                bus.err_code  <= ERR_TIMEOUT;
                bus.BRAM_Opts <= OPT_STP;
                state         <= S_STOP;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.cmd_start) begin
                            if (bus.cmd_depth != '0) begin
                                depth_m1       <= bus.cmd_depth - DEPTH_ONE;
                                rep_q          <= bus.cmd_repeat;
                                bus.BRAM_Depth <= 16'(bus.cmd_depth);
                                bus.err_code   <= ERR_NONE;
                                bus.busy       <= 1'b1;
                                bus.BRAM_en    <= 1'b1;
                                bus.BRAM_Opts  <= OPT_RST;
                                beat           <= '0;
                                pass           <= '0;
                                state          <= S_RST;
                            end else begin
                                bus.err_code <= ERR_ABORT;
                            end
                        end
                    end
                    S_RST: begin
                        if (bus.BRAM_Status == STS_RST) begin
                            bus.BRAM_Opts <= OPT_WR;
                            state         <= S_WR;
                        end
                    end
                    S_WR, S_RD: begin
                        if (run_beat) begin
                            if (run_last != beat_is_last) begin
                                bus.err_code  <= ERR_TLAST;
                                bus.BRAM_Opts <= OPT_STP;
                                state         <= S_STOP;
                            end else if (beat_is_last) begin
                                bus.BRAM_Opts <= OPT_STP;
                                state         <= (state == S_WR) ? S_WSTOP : S_RSTOP;
                            end else begin
                                beat <= beat + DEPTH_ONE;
                            end
                        end
                    end
                    S_WSTOP: begin
                        if (bus.BRAM_Status == STS_WAIT) begin
                            beat          <= '0;
                            pass          <= '0;
                            bus.BRAM_Opts <= OPT_RD;
                            state         <= S_RD;
                        end
                    end
                    S_RSTOP: begin
                        if (bus.BRAM_Status == STS_WAIT) begin
                            if (pass < rep_q) begin
                                pass          <= pass + PASS_ONE;
                                beat          <= '0;
                                bus.BRAM_Opts <= OPT_RD;
                                state         <= S_RD;
                            end else begin
                                bus.done <= 1'b1;
                                state    <= S_DONE;
                            end
                        end
                    end
                    S_DONE, S_STOP: begin
                        bus.busy    <= 1'b0;
                        bus.BRAM_en <= 1'b0;
                        state       <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bram_array_ctrl.sv
// Self-checking bench for bram_array_ctrl: a behavioural array model answers BRAM_Opts on BRAM_Status,
// table-driven runs plus hand sequences for abort, reset and status-wait corners.
module tb_bram_array_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bram_array_ctrl_if #(.DEPTH_W(16), .REPEAT_W(8)) bus ();

    bram_array_ctrl #(
        .DEPTH_W(16), .REPEAT_W(8), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct {
        logic [1:0]  err;
        int          ndone;
        logic [15:0] depth;
        logic [31:0] seq;
        int          len;
    } exp_t;

    typedef struct {
        int         depth;
        int         rep;
        int         wr_at;
        int         rd_at;
        logic [1:0] exp_err;
        int         exp_done;
    } vec_t;

    exp_t sb[$];
    int   ncmp = 0;
    int   nerr = 0;
    logic hold_status = 1'b0;

    // Array model: status follows the last command one cycle later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)           bus.BRAM_Status <= 2'b00;
        else if (hold_status) bus.BRAM_Status <= 2'b10;
        else begin
            case (bus.BRAM_Opts)
                2'b00:   bus.BRAM_Status <= 2'b00;
                2'b01:   bus.BRAM_Status <= 2'b10;
                2'b10:   bus.BRAM_Status <= 2'b11;
                default: bus.BRAM_Status <= 2'b01;
            endcase
        end
    end

    // Run tracer: sequence of distinct Opts values and done pulses while busy.
    logic        busy_d = 1'b0;
    logic [31:0] tr_seq = '0;
    int          tr_len = 0;
    int          tr_done = 0;
    always @(negedge clk) begin
        busy_d <= bus.busy;
        if (bus.busy && !busy_d) begin
            tr_seq  <= {30'b0, bus.BRAM_Opts};
            tr_len  <= 1;
            tr_done <= 0;
        end else if (bus.busy) begin
            if (bus.BRAM_Opts != tr_seq[1:0]) begin
                tr_seq <= {tr_seq[29:0], bus.BRAM_Opts};
                tr_len <= tr_len + 1;
            end
            if (bus.done) tr_done <= tr_done + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        ncmp++;
        if (act !== want) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    function automatic exp_t add(input exp_t e, input logic [1:0] v);
        exp_t r = e;
        r.seq = {e.seq[29:0], v};
        r.len = e.len + 1;
        return r;
    endfunction

    function automatic exp_t mk(input logic [1:0] err, input int ndone, input int depth);
        exp_t e;
        e.err = err; e.ndone = ndone; e.depth = 16'(depth); e.seq = '0; e.len = 0;
        return e;
    endfunction

    function automatic exp_t model(input vec_t v);
        exp_t e = mk(v.exp_err, v.exp_done, v.depth);
        e = add(e, 2'b00); e = add(e, 2'b01); e = add(e, 2'b11);
        if (v.wr_at == v.depth - 1) begin
            for (int p = 0; p <= v.rep; p++) begin
                e = add(e, 2'b10); e = add(e, 2'b11);
                if (v.rd_at != v.depth - 1) break;
            end
        end
        return e;
    endfunction

    task automatic pop_cmp(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            ncmp++; nerr++;
            $display("FAIL %s: run ended, got nothing queued, want an expectation", name);
            return;
        end
        e = sb.pop_front();
        chk({name, ".err"},   32'(bus.err_code),   32'(e.err));
        chk({name, ".done"},  32'(tr_done),        32'(e.ndone));
        chk({name, ".depth"}, 32'(bus.BRAM_Depth), 32'(e.depth));
        chk({name, ".opts"},  tr_seq,              e.seq);
        chk({name, ".nopts"}, 32'(tr_len),         32'(e.len));
    endtask

    task automatic set_tap(input bit rd, input logic v, input logic r, input logic l);
        if (rd) begin bus.rd_tvalid = v; bus.rd_tready = r; bus.rd_tlast = l; end
        else    begin bus.wr_tvalid = v; bus.wr_tready = r; bus.wr_tlast = l; end
    endtask

    // Gap cycles carry a random tlast with valid&ready never both high.
    task automatic drive_beats(input bit rd, input int n, input int last_at);
        logic v;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < 2 && $urandom_range(0, 3) == 0; g++) begin
                v = 1'($urandom_range(0, 1));
                set_tap(rd, v, !v, 1'($urandom_range(0, 1)));
                @(negedge clk);
            end
            set_tap(rd, 1'b1, 1'b1, i == last_at);
            @(negedge clk);
        end
        set_tap(rd, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_opts(input logic [1:0] v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (bus.BRAM_Opts === v) begin ok = 1'b1; return; end
            @(negedge clk);
        end
        ncmp++; nerr++;
        $display("FAIL wait_opts: got Opts=%b after 300 cycles, want %b", bus.BRAM_Opts, v);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 500; i++) begin
            if (bus.busy === 1'b0) return;
            @(negedge clk);
        end
        ncmp++; nerr++;
        $display("FAIL wait_idle: got busy=%b after 500 cycles, want 0", bus.busy);
    endtask

    task automatic start(input int depth, input int rep);
        @(negedge clk);
        bus.cmd_start  = 1'b1;
        bus.cmd_depth  = 16'(depth);
        bus.cmd_repeat = 8'(rep);
        @(negedge clk);
        bus.cmd_start  = 1'b0;
    endtask

    task automatic run_vec(input string name, input vec_t v);
        bit ok;
        int n;
        sb.push_back(model(v));
        start(v.depth, v.rep);
        wait_opts(2'b01, ok);
        if (ok) begin
            n = ((v.wr_at < v.depth - 1) ? v.wr_at : v.depth - 1) + 1;
            drive_beats(1'b0, n, v.wr_at);
            if (v.wr_at == v.depth - 1) begin
                for (int p = 0; p <= v.rep; p++) begin
                    wait_opts(2'b10, ok);
                    if (!ok) break;
                    n = ((v.rd_at < v.depth - 1) ? v.rd_at : v.depth - 1) + 1;
                    drive_beats(1'b1, n, v.rd_at);
                    if (v.rd_at != v.depth - 1) break;
                end
            end
        end
        wait_idle();
        pop_cmp(name);
    endtask

    initial begin
        vec_t vecs[7];
        exp_t e;
        bit   ok;

        //          depth rep wr_at rd_at err    done
        vecs[0] = '{4,    0,  3,    3,    2'b00, 1};
        vecs[1] = '{3,    2,  2,    2,    2'b00, 1};
        vecs[2] = '{4,    0,  1,    3,    2'b01, 0};
        vecs[3] = '{1,    0,  0,    0,    2'b00, 1};
        vecs[4] = '{5,    1,  4,    5,    2'b01, 0};
        vecs[5] = '{2,    3,  1,    1,    2'b00, 1};
        vecs[6] = '{6,    1,  5,    2,    2'b01, 0};

        bus.cmd_start = 1'b0; bus.cmd_depth = '0; bus.cmd_repeat = '0; bus.cmd_abort = 1'b0;
        set_tap(1'b0, 1'b0, 1'b0, 1'b0);
        set_tap(1'b1, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("rst.en",    32'(bus.BRAM_en),    32'd0);
        chk("rst.opts",  32'(bus.BRAM_Opts),  32'd3);
        chk("rst.depth", 32'(bus.BRAM_Depth), 32'd0);
        chk("rst.busy",  32'(bus.busy),       32'd0);
        chk("rst.done",  32'(bus.done),       32'd0);
        chk("rst.err",   32'(bus.err_code),   32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Zero depth is rejected in IDLE with the abort code.
        start(0, 0);
        chk("zero.err",  32'(bus.err_code), 32'd3);
        chk("zero.busy", 32'(bus.busy),     32'd0);
        chk("zero.en",   32'(bus.BRAM_en),  32'd0);
        repeat (2) @(negedge clk);
        chk("zero.busy_later", 32'(bus.busy), 32'd0);
        chk("zero.done",       32'(bus.done), 32'd0);

        for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Abort after 2 of 5 playback beats; a second start mid-run must not relatch depth.
        e = mk(2'b11, 0, 5);
        e = add(e, 2'b00); e = add(e, 2'b01); e = add(e, 2'b11); e = add(e, 2'b10); e = add(e, 2'b11);
        sb.push_back(e);
        start(5, 0);
        wait_opts(2'b01, ok);
        bus.cmd_start = 1'b1; bus.cmd_depth = 16'd9;
        @(negedge clk);
        bus.cmd_start = 1'b0;
        drive_beats(1'b0, 5, 4);
        wait_opts(2'b10, ok);
        drive_beats(1'b1, 2, 4);
        bus.cmd_abort = 1'b1;
        @(negedge clk);
        bus.cmd_abort = 1'b0;
        chk("abort.stop_opts", 32'(bus.BRAM_Opts), 32'd3);
        chk("abort.stop_en",   32'(bus.BRAM_en),   32'd1);
        chk("abort.stop_busy", 32'(bus.busy),      32'd1);
        chk("abort.stop_err",  32'(bus.err_code),  32'd3);
        @(negedge clk);
        chk("abort.idle_en",   32'(bus.BRAM_en),   32'd0);
        chk("abort.idle_busy", 32'(bus.busy),      32'd0);
        pop_cmp("abort");

        // Asynchronous reset in the middle of the fill.
        e = mk(2'b00, 0, 0);
        e = add(e, 2'b00); e = add(e, 2'b01);
        sb.push_back(e);
        start(6, 0);
        wait_opts(2'b01, ok);
        drive_beats(1'b0, 2, 9);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.en",   32'(bus.BRAM_en),   32'd0);
        chk("arst.opts", 32'(bus.BRAM_Opts), 32'd3);
        chk("arst.busy", 32'(bus.busy),      32'd0);
        @(negedge clk);
        pop_cmp("arst");
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Array never reports WAITING after the fill.
`ifdef BRAM_CTRL_TIMEOUT_EN
        e = mk(2'b10, 0, 2);
`else
        e = mk(2'b11, 0, 2);
`endif
        e = add(e, 2'b00); e = add(e, 2'b01); e = add(e, 2'b11);
        sb.push_back(e);
        start(2, 0);
        wait_opts(2'b01, ok);
        hold_status = 1'b1;
        drive_beats(1'b0, 2, 1);
        repeat (40) @(negedge clk);
`ifdef BRAM_CTRL_TIMEOUT_EN
        chk("wd.busy", 32'(bus.busy),      32'd0);
        chk("wd.en",   32'(bus.BRAM_en),   32'd0);
        chk("wd.opts", 32'(bus.BRAM_Opts), 32'd3);
`else
        chk("wd.busy", 32'(bus.busy),      32'd1);
        chk("wd.en",   32'(bus.BRAM_en),   32'd1);
        chk("wd.opts", 32'(bus.BRAM_Opts), 32'd3);
        bus.cmd_abort = 1'b1;
        @(negedge clk);
        bus.cmd_abort = 1'b0;
`endif
        wait_idle();
        pop_cmp("wd");
        hold_status = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
